rv32i_single_cycle_top: RTL and testbench
=========================================

# rv32i_single_cycle_top

Single-cycle RV32I processor top level: program counter, instruction memory, 32×32 register file, ALU, branch unit, immediate generator and byte-addressable data memory in one block. It executes the 37 integer instructions listed under Operation, one per clock. It exposes fetch and data-memory activity on observation outputs, grouped in the `riscv_io` signal bundle, for self-checking benches.

## Interface
- MP_DATA_WIDTH, 32: register, ALU and data-memory word width. Only 32 is supported.
- MP_ADDR_WIDTH, 32: width of the PC and of byte addresses.
- MP_IMEM_DEPTH, 256: instruction memory depth in words.
- MP_DMEM_DEPTH, 64: data memory depth in words.
- MP_IMEM_FILE, "imem.hex": hex image loaded into instruction memory with $readmemh at time 0.
- iclk  in  1: the single clock. All state updates on the rising edge.
- irst_n  in  1: reset. Asynchronous, active-low.
- oinstr  out  32: instruction currently fetched at opc.
- opc  out  MP_ADDR_WIDTH: current program counter.
- odmem_addr  out  MP_ADDR_WIDTH: data-memory byte address, equal to the ALU result.
- odmem_wr_en  out  1: high for the current instruction if it is a store.
- odmem_wr_data  out  MP_DATA_WIDTH: rs2 value, unshifted and unmasked.
- odmem_rd_data  out  MP_DATA_WIDTH: raw data-memory word at odmem_addr[..:2].

## Operation
- Supported instructions:
  - lui, auipc, jal, jalr
  - beq, bne, blt, bge, bltu, bgeu
  - lb, lh, lw, lbu, lhu
  - sb, sh, sw
  - addi, slti, sltiu, xori, ori, andi, slli, srli, srai
  - add, sub, sll, slt, sltu, xor, or, and, srl, sra
- Any other opcode executes as a NOP: no register write, no memory write, PC+4.
- Immediates use the standard RISC-V I/S/B/U/J formats, sign-extended.
- Shifts use bits [4:0] of the amount. sra/srai are arithmetic.
- slt/slti compare signed. sltu/sltiu compare unsigned. All produce 0 or 1.
- x0 always reads 0. Writes to x0 are dropped.
- jal/jalr write PC+4 to rd. The jalr target is (rs1+imm) with bit 0 cleared.
- auipc writes PC+imm. lui writes imm<<12.
- Branch target is PC+imm; otherwise the next PC is PC+4.
- Data memory is little-endian, word-organized, indexed by addr[..:2] modulo MP_DMEM_DEPTH.
- Instruction memory is indexed by pc[..:2] modulo MP_IMEM_DEPTH.
- Loads select bytes by addr[1:0] within the addressed word:
  - lb/lbu return byte k, sign-extended or zero-extended.
  - lh/lhu return byte (k+1 mod 4) as the high byte and byte k as the low byte, so offset 3 wraps to byte 0 of the same word.
  - lw ignores addr[1:0].
- Stores are byte-lane writes at the same offset:
  - sb writes byte k with rs2[7:0].
  - sh writes byte k with rs2[7:0] and byte (k+1 mod 4) with rs2[15:8], wrapping within the word.
  - sw writes the whole word.
- Register file and data memory are not initialized except as stated under Timing.

## Timing
- Single-cycle: fetch, decode, execute, memory access and writeback all complete within one clock.
- All outputs are combinational from the current PC and state. They are stable before the falling edge.
- On the rising edge:
  - PC takes the next PC.
  - The register file writes rd.
  - Data memory applies the enabled byte lanes.
- A load result is read combinationally and written to rd at the same edge.
- A load directly after a store to the same word sees the stored data, since the write occurred at the prior edge.
- While irst_n is low:
  - PC = 0 and all registers x1–x31 = 0, asynchronously.
  - odmem_wr_en is forced 0, and no register or memory writes occur.
  - oinstr shows imem[0] and opc = 0.
- On deassertion, the first rising edge executes the instruction at address 0.
- Reset asserted mid-program aborts the current instruction immediately; no partial write occurs.

## Test plan
- Arithmetic: lw/addi/add/sub/or/and/jal program ending in sw x,100(x0) -> odmem_wr_en=1, odmem_addr=100, odmem_wr_data=25 at that cycle.
- Upper immediates: lui 1 -> stored 4096. auipc 1 at PC 0x58 -> stored 4184. jalr link value -> stored 104.
- Shifts: x=-77 gives:
  - slli 1 -> -154
  - srli 1 -> 2147483609
  - srai 1 -> -39
  - Same results for sll/srl/sra with a register amount of 1.
- Loads: word 0xAA0BC0DD at address 96.
  - lb 96..99 -> -35, -64, 11, -86
  - lh 96..99 -> -16163, 3008, -22005, -8790
  - lbu 96..99 -> 221, 192, 11, 170
  - lhu 96..99 -> 49373, 3008, 43531, 56746
- Branches:
  - Taken/not-taken pairs for beq/bne/blt/bge/bltu/bgeu with -1 vs 1 operands; signed and unsigned orderings must differ.
  - slt(-1,1)=1, sltu(-1,1)=0.
- Reset: assert irst_n for 22 ns from time 0 -> opc=0 and odmem_wr_en=0 throughout. Reassert mid-run -> opc returns to 0 asynchronously and no store is issued.

Source files
------------

// File: rtl/rv32i_single_cycle_top.sv
// Single-cycle RV32I core: fetch, decode, execute, memory and writeback in one clock.
// Fetch and data-memory activity are exposed as the riscv_io observation outputs.
module rv32i_single_cycle_top #(
  parameter int    MP_DATA_WIDTH = 32,
  parameter int    MP_ADDR_WIDTH = 32,
  parameter int    MP_IMEM_DEPTH = 256,
  parameter int    MP_DMEM_DEPTH = 64,
  parameter string MP_IMEM_FILE  = "imem.hex"
) (
  input  logic                     iclk,
  input  logic                     irst_n,
  // riscv_io observation bundle
  output logic [31:0]              oinstr,
  output logic [MP_ADDR_WIDTH-1:0] opc,
  output logic [MP_ADDR_WIDTH-1:0] odmem_addr,
  output logic                     odmem_wr_en,
  output logic [MP_DATA_WIDTH-1:0] odmem_wr_data,
  output logic [MP_DATA_WIDTH-1:0] odmem_rd_data
);

  localparam int IMEM_AW = $clog2(MP_IMEM_DEPTH);
  localparam int DMEM_AW = $clog2(MP_DMEM_DEPTH);

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;

  logic [31:0]              imem_r [MP_IMEM_DEPTH];
  logic [31:0]              dmem_r [MP_DMEM_DEPTH];
  logic [31:0]              regs_r [32];
  logic [MP_ADDR_WIDTH-1:0] pc_r;
  logic [MP_ADDR_WIDTH-1:0] pc_next_s;
  logic [MP_ADDR_WIDTH-1:0] pc_plus4_s;

  logic [31:0] instr_s;
  logic [6:0]  opcode_s;
  logic [4:0]  rd_s;
  logic [4:0]  rs1_s;
  logic [4:0]  rs2_s;
  logic [2:0]  funct3_s;
  logic [31:0] imm_i_s;
  logic [31:0] imm_s_s;
  logic [31:0] imm_b_s;
  logic [31:0] imm_u_s;
  logic [31:0] imm_j_s;
  logic [31:0] rs1_val_s;
  logic [31:0] rs2_val_s;
  logic [31:0] alu_s;
  logic [31:0] wb_s;
  logic        reg_we_s;
  logic        store_s;
  logic        br_taken_s;
  logic [31:0] word_s;
  logic [31:0] load_data_s;
  logic        load_ok_s;
  logic [1:0]  k_s;
  logic [1:0]  k1_s;
  logic [7:0]  byte_lo_s;
  logic [7:0]  byte_hi_s;
  logic [3:0]       lane_we_s;
  logic [3:0][7:0]  lane_data_s;
  logic [DMEM_AW-1:0] dmem_idx_s;

  function automatic logic [31:0] alu_fn(input logic [2:0] f3, input logic alt,
                                         input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (f3)
      3'b000: r = alt ? (a - b) : (a + b);
      3'b001: r = a << b[4:0];
      3'b010: r = {31'h0, ($signed(a) < $signed(b))};
      3'b011: r = {31'h0, (a < b)};
      3'b100: r = a ^ b;
      3'b101: begin
        if (alt) r = $unsigned($signed(a) >>> b[4:0]);
        else     r = a >> b[4:0];
      end
      3'b110: r = a | b;
      3'b111: r = a & b;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  assign instr_s    = imem_r[pc_r[IMEM_AW+1:2]];
  assign opcode_s   = instr_s[6:0];
  assign rd_s       = instr_s[11:7];
  assign funct3_s   = instr_s[14:12];
  assign rs1_s      = instr_s[19:15];
  assign rs2_s      = instr_s[24:20];
  assign imm_i_s    = {{20{instr_s[31]}}, instr_s[31:20]};
  assign imm_s_s    = {{20{instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
  assign imm_b_s    = {{19{instr_s[31]}}, instr_s[31], instr_s[7], instr_s[30:25], instr_s[11:8], 1'b0};
  assign imm_u_s    = {instr_s[31:12], 12'h000};
  assign imm_j_s    = {{11{instr_s[31]}}, instr_s[31], instr_s[19:12], instr_s[20], instr_s[30:21], 1'b0};
  assign rs1_val_s  = (rs1_s == 5'd0) ? 32'h0 : regs_r[rs1_s];
  assign rs2_val_s  = (rs2_s == 5'd0) ? 32'h0 : regs_r[rs2_s];
  assign pc_plus4_s = pc_r + 32'd4;

  // ALU result doubles as data-memory address and control-transfer target.
  always_comb begin
    alu_s = 32'h0;
    case (opcode_s)
      OPC_LUI:            alu_s = imm_u_s;
      OPC_AUIPC:          alu_s = pc_r + imm_u_s;
      OPC_JAL:            alu_s = pc_r + imm_j_s;
      OPC_JALR, OPC_LOAD: alu_s = rs1_val_s + imm_i_s;
      OPC_BRANCH:         alu_s = pc_r + imm_b_s;
      OPC_STORE:          alu_s = rs1_val_s + imm_s_s;
      OPC_OPIMM:          alu_s = alu_fn(funct3_s, (funct3_s == 3'b101) && instr_s[30], rs1_val_s, imm_i_s);
      OPC_OP:             alu_s = alu_fn(funct3_s, instr_s[30], rs1_val_s, rs2_val_s);
      default:            alu_s = 32'h0;
    endcase
  end

  // Branch condition evaluation.
  always_comb begin
    br_taken_s = 1'b0;
    case (funct3_s)
      3'b000:  br_taken_s = (rs1_val_s == rs2_val_s);
      3'b001:  br_taken_s = (rs1_val_s != rs2_val_s);
      3'b100:  br_taken_s = ($signed(rs1_val_s) <  $signed(rs2_val_s));
      3'b101:  br_taken_s = ($signed(rs1_val_s) >= $signed(rs2_val_s));
      3'b110:  br_taken_s = (rs1_val_s <  rs2_val_s);
      3'b111:  br_taken_s = (rs1_val_s >= rs2_val_s);
      default: br_taken_s = 1'b0;
    endcase
  end

  assign dmem_idx_s = alu_s[DMEM_AW+1:2];
  assign word_s     = dmem_r[dmem_idx_s];
  assign k_s        = alu_s[1:0];
  assign k1_s       = k_s + 2'd1;
  // Halfword high byte wraps inside the addressed word rather than crossing into the next.
  assign byte_lo_s  = word_s[{k_s, 3'b000} +: 8];
  assign byte_hi_s  = word_s[{k1_s, 3'b000} +: 8];

  // Load extraction and sign/zero extension.
  always_comb begin
    load_data_s = 32'h0;
    load_ok_s   = 1'b1;
    case (funct3_s)
      3'b000:  load_data_s = {{24{byte_lo_s[7]}}, byte_lo_s};
      3'b001:  load_data_s = {{16{byte_hi_s[7]}}, byte_hi_s, byte_lo_s};
      3'b010:  load_data_s = word_s;
      3'b100:  load_data_s = {24'h0, byte_lo_s};
      3'b101:  load_data_s = {16'h0, byte_hi_s, byte_lo_s};
      default: load_ok_s   = 1'b0;
    endcase
  end

  // Store byte-lane enables and data.
  always_comb begin
    lane_we_s   = 4'h0;
    lane_data_s = 32'h0;
    case (funct3_s)
      3'b000: begin
        lane_we_s[k_s]   = 1'b1;
        lane_data_s[k_s] = rs2_val_s[7:0];
      end
      3'b001: begin
        lane_we_s[k_s]    = 1'b1;
        lane_we_s[k1_s]   = 1'b1;
        lane_data_s[k_s]  = rs2_val_s[7:0];
        lane_data_s[k1_s] = rs2_val_s[15:8];
      end
      3'b010: begin
        lane_we_s   = 4'hf;
        lane_data_s = rs2_val_s;
      end
      default: lane_we_s = 4'h0;
    endcase
  end

  // Writeback selection and next-PC.
  always_comb begin
    wb_s      = alu_s;
    reg_we_s  = 1'b0;
    store_s   = 1'b0;
    pc_next_s = pc_plus4_s;
    case (opcode_s)
      OPC_LUI, OPC_AUIPC, OPC_OPIMM, OPC_OP: reg_we_s = 1'b1;
      OPC_JAL: begin
        wb_s      = pc_plus4_s;
        reg_we_s  = 1'b1;
        pc_next_s = alu_s;
      end
      OPC_JALR: begin
        wb_s      = pc_plus4_s;
        reg_we_s  = 1'b1;
        pc_next_s = {alu_s[31:1], 1'b0};
      end
      OPC_BRANCH: begin
        if (br_taken_s) pc_next_s = alu_s;
        else            pc_next_s = pc_plus4_s;
      end
      OPC_LOAD: begin
        wb_s     = load_data_s;
        reg_we_s = load_ok_s;
      end
      OPC_STORE: store_s = (funct3_s == 3'b000) || (funct3_s == 3'b001) || (funct3_s == 3'b010);
      default:   reg_we_s = 1'b0;
    endcase
  end

  // Program counter.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) pc_r <= 32'h0;
    else         pc_r <= pc_next_s;
  end

  // Register file; x0 is never written.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      for (int i = 0; i < 32; i++) regs_r[i] <= 32'h0;
    end else if (reg_we_s && (rd_s != 5'd0)) begin
      regs_r[rd_s] <= wb_s;
    end
  end

  // Data memory byte-lane writes; the enable already carries the reset gate.
  always_ff @(posedge iclk) begin
    if (odmem_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_we_s[i]) dmem_r[dmem_idx_s][8*i +: 8] <= lane_data_s[i];
      end
    end
  end

  assign oinstr        = instr_s;
  assign opc           = pc_r;
  assign odmem_addr    = alu_s;
  assign odmem_wr_en   = store_s & irst_n;
  assign odmem_wr_data = rs2_val_s;
  assign odmem_rd_data = word_s;

endmodule

// File: tb/tb_rv32i_single_cycle_top.sv
// Directed bench: assembles a program into the instruction ROM and checks every
// store seen on the data-memory port, plus reset behaviour.
module tb_rv32i_single_cycle_top;

  localparam int OPI = 7'h13, OPR = 7'h33, LD = 7'h03, LUI = 7'h37, AUIPC = 7'h17, JALR = 7'h67;

  logic        iclk   = 1'b0;
  logic        irst_n = 1'b0;
  logic [31:0] oinstr, opc, odmem_addr, odmem_wr_data, odmem_rd_data;
  logic        odmem_wr_en;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] prog [$];
  logic [31:0] exp_addr [$];
  logic [31:0] exp_data [$];
  logic [31:0] end_pc;

  rv32i_single_cycle_top #(.MP_IMEM_FILE("")) dut (
    .iclk          (iclk),
    .irst_n        (irst_n),
    .oinstr        (oinstr),
    .opc           (opc),
    .odmem_addr    (odmem_addr),
    .odmem_wr_en   (odmem_wr_en),
    .odmem_wr_data (odmem_wr_data),
    .odmem_rd_data (odmem_rd_data)
  );

  always #5 iclk = ~iclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
    logic [31:0] im, a, f, d, o;
    im = imm; a = rs1; f = f3; d = rd; o = op;
    return {im[11:0], a[4:0], f[2:0], d[4:0], o[6:0]};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] im, a, b, f;
    im = imm; a = rs1; b = rs2; f = f3;
    return {im[11:5], b[4:0], a[4:0], f[2:0], im[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] im, a, b, f;
    im = imm; a = rs1; b = rs2; f = f3;
    return {im[12], im[10:5], b[4:0], a[4:0], f[2:0], im[4:1], im[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
    logic [31:0] s, a, b, f, d;
    s = f7; a = rs1; b = rs2; f = f3; d = rd;
    return {s[6:0], b[4:0], a[4:0], f[2:0], d[4:0], 7'h33};
  endfunction

  function automatic logic [31:0] enc_u(input int imm20, input int rd, input int op);
    logic [31:0] im, d, o;
    im = imm20; d = rd; o = op;
    return {im[19:0], d[4:0], o[6:0]};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [31:0] im, d;
    im = imm; d = rd;
    return {im[20], im[10:1], im[11], im[19:12], d[4:0], 7'h6f};
  endfunction

  task automatic emit(input logic [31:0] w);
    prog.push_back(w);
  endtask

  task automatic expect_st(input logic [31:0] a, input logic [31:0] d);
    exp_addr.push_back(a);
    exp_data.push_back(d);
  endtask

  // sw rs,100(x0) with the value rs is expected to hold
  task automatic st100(input int rs, input logic [31:0] val);
    emit(enc_s(100, rs, 0, 2));
    expect_st(32'd100, val);
  endtask

  task automatic build_prog();
    int ld_f3 [4] = '{0, 1, 4, 5};
    int ld_exp [4][4] = '{'{-35, -64, 11, -86}, '{-16163, 3008, -22005, -8790},
                          '{221, 192, 11, 170}, '{49373, 3008, 43531, 56746}};
    // f3, rs1, rs2, expected x22 (0 = taken, 1 = fell through)
    int br [12][4] = '{'{0,20,21,1}, '{0,20,20,0}, '{1,20,21,0}, '{1,20,20,1},
                       '{4,20,21,0}, '{4,21,20,1}, '{5,20,21,1}, '{5,21,20,0},
                       '{6,20,21,1}, '{6,21,20,0}, '{7,20,21,0}, '{7,21,20,1}};
    emit(enc_i(5, 0, 0, 1, OPI));
    emit(enc_i(12, 0, 0, 2, OPI));
    emit(enc_s(96, 2, 0, 2)); expect_st(32'd96, 32'd12);
    emit(enc_i(96, 0, 2, 3, LD));
    emit(enc_r(0, 3, 1, 0, 4));
    emit(enc_r(32, 1, 4, 0, 5));
    emit(enc_r(0, 2, 1, 6, 6));
    emit(enc_r(0, 2, 1, 7, 7));
    emit(enc_r(0, 5, 6, 0, 8));
    emit(enc_j(8, 9));
    emit(enc_i(0, 0, 0, 8, OPI));
    st100(8, 32'd25);
    emit(enc_s(104, 9, 0, 2)); expect_st(32'd104, 32'd40);
    emit(enc_u(1, 10, LUI)); st100(10, 32'd4096);
    emit(enc_i(-77, 0, 0, 11, OPI));
    emit(enc_i(1, 11, 1, 12, OPI));    st100(12, 32'hffffff66);
    emit(enc_i(1, 11, 5, 12, OPI));    st100(12, 32'd2147483609);
    emit(enc_i(1025, 11, 5, 12, OPI)); st100(12, 32'hffffffd9);
    emit(enc_u(1, 13, AUIPC));         st100(13, 32'd4184);
    emit(enc_i(1, 0, 0, 14, OPI));
    emit(enc_i(109, 0, 0, 15, JALR));
    emit(enc_i(0, 0, 0, 15, OPI));
    st100(15, 32'd104);
    emit(enc_r(0, 14, 11, 1, 12));  st100(12, 32'hffffff66);
    emit(enc_r(0, 14, 11, 5, 12));  st100(12, 32'd2147483609);
    emit(enc_r(32, 14, 11, 5, 12)); st100(12, 32'hffffffd9);
    emit(enc_u(32'haa0bc, 16, LUI));
    emit(enc_i(221, 16, 0, 16, OPI));
    emit(enc_s(96, 16, 0, 2)); expect_st(32'd96, 32'haa0bc0dd);
    for (int m = 0; m < 4; m++) begin
      for (int k = 0; k < 4; k++) begin
        emit(enc_i(96 + k, 0, ld_f3[m], 17, LD));
        st100(17, ld_exp[m][k]);
      end
    end
    emit(enc_i(-1, 0, 0, 20, OPI));
    emit(enc_i(1, 0, 0, 21, OPI));
    for (int b = 0; b < 12; b++) begin
      emit(enc_i(0, 0, 0, 22, OPI));
      emit(enc_b(8, br[b][2], br[b][1], br[b][0]));
      emit(enc_i(1, 0, 0, 22, OPI));
      st100(22, br[b][3]);
    end
    emit(enc_r(0, 21, 20, 2, 23)); st100(23, 32'd1);
    emit(enc_r(0, 21, 20, 3, 23)); st100(23, 32'd0);
    emit(enc_i(1, 20, 2, 24, OPI));   st100(24, 32'd1);
    emit(enc_i(-1, 21, 3, 24, OPI));  st100(24, 32'd1);
    emit(enc_i(-1, 21, 4, 24, OPI));  st100(24, 32'hfffffffe);
    emit(enc_i(112, 21, 6, 24, OPI)); st100(24, 32'd113);
    emit(enc_i(90, 20, 7, 24, OPI));  st100(24, 32'd90);
    emit(enc_r(0, 21, 20, 4, 24));    st100(24, 32'hfffffffe);
    emit(enc_i(5, 0, 0, 0, OPI));     st100(0, 32'd0);
    emit({12'h123, 5'd1, 3'b000, 5'd25, 7'b0001011}); st100(25, 32'd0);
    emit(enc_i(1957, 0, 0, 27, OPI));
    emit(enc_s(99, 27, 0, 1)); expect_st(32'd99, 32'd1957);
    emit(enc_i(96, 0, 2, 28, LD)); st100(28, 32'ha50bc007);
    emit(enc_s(97, 27, 0, 0)); expect_st(32'd97, 32'd1957);
    emit(enc_i(96, 0, 2, 28, LD)); st100(28, 32'ha50ba507);
    end_pc = prog.size() * 4;
    emit(enc_j(0, 0));
  endtask

  task automatic run_pass(input int pass);
    int idx;
    idx = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge iclk);
      if (odmem_wr_en) begin
        if (idx < exp_addr.size()) begin
          check_eq($sformatf("p%0d_st%0d_addr", pass, idx), odmem_addr, exp_addr[idx]);
          check_eq($sformatf("p%0d_st%0d_data", pass, idx), odmem_wr_data, exp_data[idx]);
        end
        idx++;
      end
      if (opc == end_pc) break;
    end
    check_eq($sformatf("p%0d_end_pc", pass), opc, end_pc);
    check_eq($sformatf("p%0d_store_count", pass), idx, exp_addr.size());
  endtask

  initial begin
    build_prog();
    for (int i = 0; i < prog.size(); i++) dut.imem_r[i] = prog[i];

    #2;
    for (int t = 0; t < 4; t++) begin
      check_eq($sformatf("rst_pc_%0d", t), opc, 32'h0);
      check_eq($sformatf("rst_wr_en_%0d", t), {31'h0, odmem_wr_en}, 32'h0);
      check_eq($sformatf("rst_instr_%0d", t), oinstr, prog[0]);
      #5;
    end
    irst_n = 1'b1;
    run_pass(1);

    @(negedge iclk);
    irst_n = 1'b0;
    @(negedge iclk);
    #2 irst_n = 1'b1;
    for (int c = 0; c < 20 && opc !== 32'd8; c++) @(negedge iclk);
    check_eq("p2_reach_sw", opc, 32'd8);
    check_eq("p2_sw_wr_en", {31'h0, odmem_wr_en}, 32'h1);
    #2 irst_n = 1'b0;
    #1;
    check_eq("abort_pc_async", opc, 32'h0);
    check_eq("abort_wr_en", {31'h0, odmem_wr_en}, 32'h0);
    for (int c = 0; c < 2; c++) begin
      @(negedge iclk);
      check_eq($sformatf("abort_hold_pc_%0d", c), opc, 32'h0);
      check_eq($sformatf("abort_hold_wr_en_%0d", c), {31'h0, odmem_wr_en}, 32'h0);
    end
    #2 irst_n = 1'b1;
    run_pass(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
